// File: rtl/cam_csi_rx_stream_select.sv
// Frame-safe camera stream selector: picks one CSI-2 RX pixel stream, switches only
// at frame starts, narrows pixels (truncate or round+saturate) and reports line/frame stats.
module cam_csi_rx_stream_select #(
   parameter int NUM_CHANNEL         = 4,
   parameter int PIXEL_PER_CLK       = 4,
   parameter int PIXEL_RX_DATAWIDTH  = 10,
   parameter int PIXEL_OUT_DATAWIDTH = 8,
   parameter int CNT_WIDTH           = 16,
   parameter int CH_SEL_W            = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [CH_SEL_W-1:0]                                   i_ch_sel,
   input  logic                                                  i_round_en,
   input  logic                                                  i_err_clr,
   input  logic [NUM_CHANNEL-1:0]                                i_vs,
   input  logic [NUM_CHANNEL-1:0]                                i_hs,
   input  logic [NUM_CHANNEL-1:0]                                i_de,
   input  logic [NUM_CHANNEL*PIXEL_PER_CLK*PIXEL_RX_DATAWIDTH-1:0] i_data,
   output logic                                                  o_vs,
   output logic                                                  o_hs,
   output logic                                                  o_de,
   output logic [PIXEL_PER_CLK*PIXEL_OUT_DATAWIDTH-1:0]          o_data,
   output logic [CH_SEL_W-1:0]                                   o_active_ch,
   output logic [15:0]                                           o_frame_cnt,
   output logic [CNT_WIDTH-1:0]                                  o_line_cnt,
   output logic [CNT_WIDTH-1:0]                                  o_line_width,
   output logic                                                  o_err_line_len
);

   localparam int RXW = PIXEL_RX_DATAWIDTH;
   localparam int OW  = PIXEL_OUT_DATAWIDTH;
   localparam int D   = RXW - OW;
   localparam int PW  = PIXEL_PER_CLK * RXW;

   generate
      if (PIXEL_OUT_DATAWIDTH > PIXEL_RX_DATAWIDTH) begin : g_bad_width
         $error("PIXEL_OUT_DATAWIDTH must not exceed PIXEL_RX_DATAWIDTH");
      end
   endgenerate

   typedef enum logic {S_SYNC, S_FRAME} state_t;

   state_t                         r_state;
   logic [NUM_CHANNEL-1:0]         r_vs_d;
   logic                           r_vs1, r_hs1, r_de1, r_rise1, r_round1;
   logic [PW-1:0]                  r_data1;
   logic [CH_SEL_W-1:0]            r_active_ch;
   logic                           r_vs, r_hs, r_de;
   logic [PIXEL_PER_CLK*OW-1:0]    r_data;
   logic [15:0]                    r_frame_cnt;
   logic [CNT_WIDTH-1:0]           r_line_cnt, r_line_width, r_beat, r_ref_width;
   logic                           r_ref_valid, r_err_pend, r_err;

   logic [NUM_CHANNEL-1:0]         w_vs_rise;
   logic                           w_sel_vs, w_sel_hs, w_sel_de, w_sel_rise;
   logic [PW-1:0]                  w_sel_data;
   logic [31:0]                    w_sel_ext;
   logic                           w_sel_valid;
   logic                           w_switch, w_fwd, w_frame_start, w_de_next, w_de_fall, w_mismatch;
   logic [PIXEL_PER_CLK*OW-1:0]    w_conv;

   // Edges are detected per channel so a channel change never fabricates a vs edge.
   assign w_vs_rise   = i_vs & ~r_vs_d;
   assign w_sel_ext   = 32'(i_ch_sel);
   assign w_sel_valid = (w_sel_ext < 32'(NUM_CHANNEL));

   always_comb begin
      w_sel_vs   = 1'b0;
      w_sel_hs   = 1'b0;
      w_sel_de   = 1'b0;
      w_sel_rise = 1'b0;
      w_sel_data = '0;
      for (int c = 0; c < NUM_CHANNEL; c++) begin
         if (CH_SEL_W'(c) == r_active_ch) begin
            w_sel_vs   = i_vs[c];
            w_sel_hs   = i_hs[c];
            w_sel_de   = i_de[c];
            w_sel_rise = w_vs_rise[c];
            w_sel_data = i_data[c*PW +: PW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vs_d   <= '0;
         r_vs1    <= 1'b0;
         r_hs1    <= 1'b0;
         r_de1    <= 1'b0;
         r_rise1  <= 1'b0;
         r_round1 <= 1'b0;
         r_data1  <= '0;
      end else begin
         r_vs_d   <= i_vs;
         r_vs1    <= w_sel_vs;
         r_hs1    <= w_sel_hs;
         r_de1    <= w_sel_de;
         r_rise1  <= w_sel_rise;
         r_round1 <= i_round_en;
         r_data1  <= w_sel_data;
      end
   end

   // The rounding mode travels with its beat so a mode change applies to exactly that beat.
   generate
      for (genvar p = 0; p < PIXEL_PER_CLK; p++) begin : g_pix
         logic [RXW-1:0] w_in;
         assign w_in = r_data1[p*RXW +: RXW];
         if (D > 0) begin : g_round
            logic [OW-1:0] w_trunc;
            logic [OW:0]   w_sum;
            assign w_trunc = w_in[RXW-1 -: OW];
            assign w_sum   = {1'b0, w_trunc} + {{OW{1'b0}}, w_in[D-1]};
            assign w_conv[p*OW +: OW] = !r_round1 ? w_trunc :
                                        (w_sum[OW] ? {OW{1'b1}} : w_sum[OW-1:0]);
         end else begin : g_pass
            assign w_conv[p*OW +: OW] = w_in;
         end
      end
   endgenerate

   assign w_switch      = (r_state == S_FRAME) && r_rise1 && w_sel_valid && (i_ch_sel != r_active_ch);
   assign w_fwd         = (r_state == S_FRAME) ? !w_switch : r_rise1;
   assign w_frame_start = w_fwd && r_rise1;
   assign w_de_next     = w_fwd && r_de1;
   assign w_de_fall     = r_de && !w_de_next;
   assign w_mismatch    = w_de_fall && r_ref_valid && (r_beat != r_ref_width);

   // A line ending on a frame-start beat is still measured against the old frame's reference.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_SYNC;
         r_active_ch  <= '0;
         r_vs         <= 1'b0;
         r_hs         <= 1'b0;
         r_de         <= 1'b0;
         r_data       <= '0;
         r_frame_cnt  <= '0;
         r_line_cnt   <= '0;
         r_line_width <= '0;
         r_beat       <= '0;
         r_ref_width  <= '0;
         r_ref_valid  <= 1'b0;
         r_err_pend   <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            S_SYNC: begin
               if (r_rise1)
                  r_state <= S_FRAME;
               else if (w_sel_valid && !w_sel_rise)
                  r_active_ch <= i_ch_sel;
            end
            S_FRAME: begin
               if (w_switch) begin
                  r_state     <= S_SYNC;
                  r_active_ch <= i_ch_sel;
               end
            end
            default: r_state <= S_SYNC;
         endcase

         r_vs <= w_fwd && r_vs1;
         r_hs <= w_fwd && r_hs1;
         r_de <= w_de_next;
         if (w_fwd)
            r_data <= w_conv;

         if (w_frame_start)
            r_frame_cnt <= r_frame_cnt + 16'd1;

         if (w_frame_start)
            r_line_cnt <= '0;
         else if (w_de_fall && (r_line_cnt != {CNT_WIDTH{1'b1}}))
            r_line_cnt <= r_line_cnt + 1'b1;

         if (w_de_fall)
            r_line_width <= r_beat;

         if (w_de_fall || w_frame_start)
            r_beat <= w_de_next ? CNT_WIDTH'(1) : '0;
         else if (w_de_next && (r_beat != {CNT_WIDTH{1'b1}}))
            r_beat <= r_beat + 1'b1;

         if (w_frame_start)
            r_ref_valid <= 1'b0;
         else if (w_de_fall && !r_ref_valid) begin
            r_ref_valid <= 1'b1;
            r_ref_width <= r_beat;
         end

         r_err_pend <= w_mismatch;
         r_err      <= r_err_pend || (r_err && !i_err_clr);
      end
   end

   assign o_vs           = r_vs;
   assign o_hs           = r_hs;
   assign o_de           = r_de;
   assign o_data         = r_data;
   assign o_active_ch    = r_active_ch;
   assign o_frame_cnt    = r_frame_cnt;
   assign o_line_cnt     = r_line_cnt;
   assign o_line_width   = r_line_width;
   assign o_err_line_len = r_err;

endmodule
